bpsk_tx_frame_ctrl: RTL

Transmit-side scheduler for `bpsk_modulator_top`. It frames a payload as preamble, then sync word, then payload bytes, and pulls payload bytes from an upstream byte source through a valid/ready handshake. It drives the modulator's `en` and `in` so that each bit is held for an integer number of carrier periods, aligned to the carrier lookup cycle. It sits between the TX packet buffer and the modulator; the modulator's `cosine_lut` wiring is unchanged.

---
 rtl/bpsk_tx_frame_ctrl.sv | 294 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/bpsk_tx_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : bpsk_tx_frame_ctrl
// Description : Transmit-side frame scheduler for bpsk_modulator_top.
//               Sends a frame as preamble (1,0,1,0,...), then the sync word
//               (MSB first), then len payload bytes (MSB first). Each bit is
//               held for B = CARRIER_SAMPLES_PER_PERIOD * PERIODS_PER_BIT
//               clocks so that symbol changes line up with the carrier LUT
//               cycle. Payload bytes are pulled from an upstream source over
//               a valid/ready handshake. A missing byte aborts the frame.
//
// Ports       : clk        - system clock
//               rst_n      - asynchronous active-low reset
//               start      - one-cycle frame request, sampled in IDLE only
//               len        - payload length in bytes, latched with start
//               byte_data  - payload byte from upstream
//               byte_valid - byte_data is valid
//               byte_ready - one-cycle byte transfer strobe
//               mod_en     - modulator enable
//               mod_in     - modulator symbol bit
//               busy       - frame in progress
//               done       - one-cycle pulse on normal frame completion
//               underrun   - one-cycle pulse on frame abort (no byte)
//
// Revision    : 1.0 - initial release
// ============================================================================

`ifndef CARRIER_SAMPLES_PER_PERIOD
`define CARRIER_SAMPLES_PER_PERIOD 16
`endif

module bpsk_tx_frame_ctrl #(
    parameter int          CARRIER_SAMPLES_PER_PERIOD = `CARRIER_SAMPLES_PER_PERIOD,
    parameter int          PERIODS_PER_BIT            = 2,
    parameter int          PREAMBLE_BITS              = 16,
    parameter logic [31:0] SYNC_WORD                  = 32'h0000_00D3,
    parameter int          SYNC_BITS                  = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] len,
    input  logic [7:0] byte_data,
    input  logic       byte_valid,
    output logic       byte_ready,
    output logic       mod_en,
    output logic       mod_in,
    output logic       busy,
    output logic       done,
    output logic       underrun
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    // Clocks per bit. Must be at least 2: byte_ready is registered, so it
    // is scheduled one clock ahead of the bit boundary it marks.
    localparam int c_B        = CARRIER_SAMPLES_PER_PERIOD * PERIODS_PER_BIT;
    localparam int c_SAMP_W   = (c_B > 1) ? $clog2(c_B) : 1;

    // Bit counter must reach the longest field (preamble, sync, or 8 bits
    // within a payload byte).
    localparam int c_BIT_MAX0 = (PREAMBLE_BITS > SYNC_BITS) ? PREAMBLE_BITS : SYNC_BITS;
    localparam int c_BIT_MAX  = (c_BIT_MAX0 > 8) ? c_BIT_MAX0 : 8;
    localparam int c_BIT_W    = $clog2(c_BIT_MAX);

    localparam logic [c_SAMP_W-1:0] c_SAMP_LAST = c_SAMP_W'(c_B - 1);
    localparam logic [c_SAMP_W-1:0] c_SAMP_PRE  = c_SAMP_W'(c_B - 2);
    localparam logic [c_BIT_W-1:0]  c_PRE_LAST  = c_BIT_W'(PREAMBLE_BITS - 1);
    localparam logic [c_BIT_W-1:0]  c_SYNC_LAST = c_BIT_W'(SYNC_BITS - 1);
    localparam logic [c_BIT_W-1:0]  c_BYTE_LAST = c_BIT_W'(7);

    // Sync word left-aligned in 32 bits so its MSB sits at bit 31; the
    // shift register then serialises sync and payload with one datapath.
    localparam logic [31:0] c_SYNC_INIT = SYNC_WORD << (32 - SYNC_BITS);

    localparam logic [1:0] c_ST_IDLE     = 2'd0;
    localparam logic [1:0] c_ST_PREAMBLE = 2'd1;
    localparam logic [1:0] c_ST_SYNC     = 2'd2;
    localparam logic [1:0] c_ST_PAYLOAD  = 2'd3;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    logic [1:0]          r_state;
    logic [c_SAMP_W-1:0] r_sample_cnt;
    logic [c_BIT_W-1:0]  r_bit_cnt;
    logic [7:0]          r_byte_cnt;
    logic [7:0]          r_len;
    // Bits still to be sent after the current one, MSB next.
    logic [30:0]         r_shift;

    logic r_mod_in;
    logic r_mod_en;
    logic r_busy;
    logic r_done;
    logic r_underrun;
    logic r_byte_ready;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic        w_bit_end;
    logic        w_last_byte;
    logic        w_field_end;
    logic        w_underrun_evt;
    logic [1:0]  w_state_nxt;
    logic        w_mod_in_nxt;
    logic [30:0] w_shift_nxt;
    logic        w_active_nxt;
    logic        w_done_nxt;
    logic        w_underrun_nxt;
    logic        w_byte_ready_nxt;

    assign w_bit_end      = (r_sample_cnt == c_SAMP_LAST);
    assign w_last_byte    = (r_byte_cnt == (r_len - 8'd1));
    // r_byte_ready is high exactly on the transfer cycle.
    assign w_underrun_evt = r_byte_ready & ~byte_valid;

    always_comb begin
        w_field_end = 1'b0;
        case (r_state)
            c_ST_PREAMBLE: w_field_end = w_bit_end && (r_bit_cnt == c_PRE_LAST);
            c_ST_SYNC:     w_field_end = w_bit_end && (r_bit_cnt == c_SYNC_LAST);
            c_ST_PAYLOAD:  w_field_end = w_bit_end && (r_bit_cnt == c_BYTE_LAST) && w_last_byte;
            default:       w_field_end = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (start && (len != 8'd0)) begin
                    w_state_nxt = c_ST_PREAMBLE;
                end
            end
            c_ST_PREAMBLE: begin
                if (w_field_end) begin
                    w_state_nxt = c_ST_SYNC;
                end
            end
            c_ST_SYNC: begin
                if (w_underrun_evt) begin
                    w_state_nxt = c_ST_IDLE;
                end else if (w_field_end) begin
                    w_state_nxt = c_ST_PAYLOAD;
                end
            end
            c_ST_PAYLOAD: begin
                if (w_underrun_evt || w_field_end) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output logic (next values of the registered outputs)
    // ------------------------------------------------------------------
    always_comb begin
        w_mod_in_nxt     = r_mod_in;
        w_shift_nxt      = r_shift;
        w_active_nxt     = (w_state_nxt != c_ST_IDLE);
        w_done_nxt       = 1'b0;
        w_underrun_nxt   = w_underrun_evt;

        // Schedule byte_ready one clock ahead so that it lands on the last
        // cycle of the last sync bit, or of the LSB of any non-final byte.
        w_byte_ready_nxt = (r_sample_cnt == c_SAMP_PRE) &&
                           (((r_state == c_ST_SYNC) && (r_bit_cnt == c_SYNC_LAST)) ||
                            ((r_state == c_ST_PAYLOAD) && (r_bit_cnt == c_BYTE_LAST) &&
                             !w_last_byte));

        if (w_state_nxt == c_ST_IDLE) begin
            w_mod_in_nxt = 1'b0;
            w_shift_nxt  = '0;
            // Zero-length request completes at once; a payload that ran to
            // its last bit completes normally. An abort never gets here
            // together with a payload end, since the final byte is never
            // fetched.
            w_done_nxt   = ((r_state == c_ST_IDLE) && start && (len == 8'd0)) ||
                           ((r_state == c_ST_PAYLOAD) && w_field_end && !w_underrun_evt);
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    // First preamble bit is a one.
                    w_mod_in_nxt = 1'b1;
                end
                c_ST_PREAMBLE: begin
                    if (w_bit_end) begin
                        if (w_field_end) begin
                            w_mod_in_nxt = c_SYNC_INIT[31];
                            w_shift_nxt  = c_SYNC_INIT[30:0];
                        end else begin
                            w_mod_in_nxt = ~r_mod_in;
                        end
                    end
                end
                c_ST_SYNC, c_ST_PAYLOAD: begin
                    if (r_byte_ready) begin
                        // Accepted byte replaces the (exhausted) shift
                        // register; its MSB goes out on the next cycle.
                        w_mod_in_nxt = byte_data[7];
                        w_shift_nxt  = {byte_data[6:0], 24'd0};
                    end else if (w_bit_end) begin
                        w_mod_in_nxt = r_shift[30];
                        w_shift_nxt  = {r_shift[29:0], 1'b0};
                    end
                end
                default: begin
                    w_mod_in_nxt = 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Counters, shift register and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sample_cnt <= '0;
            r_bit_cnt    <= '0;
            r_byte_cnt   <= '0;
            r_len        <= '0;
            r_shift      <= '0;
            r_mod_in     <= 1'b0;
            r_mod_en     <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_underrun   <= 1'b0;
            r_byte_ready <= 1'b0;
        end else begin
            if ((r_state == c_ST_IDLE) && start) begin
                r_len <= len;
            end

            if ((w_state_nxt == c_ST_IDLE) || (r_state == c_ST_IDLE)) begin
                r_sample_cnt <= '0;
                r_bit_cnt    <= '0;
                r_byte_cnt   <= '0;
            end else if (w_bit_end) begin
                r_sample_cnt <= '0;
                // Bit counter restarts at each field change and, within the
                // payload, at each byte boundary.
                if ((w_state_nxt != r_state) ||
                    ((r_state == c_ST_PAYLOAD) && (r_bit_cnt == c_BYTE_LAST))) begin
                    r_bit_cnt <= '0;
                end else begin
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                end
                if ((r_state == c_ST_PAYLOAD) && (r_bit_cnt == c_BYTE_LAST)) begin
                    r_byte_cnt <= r_byte_cnt + 8'd1;
                end
            end else begin
                r_sample_cnt <= r_sample_cnt + 1'b1;
            end

            r_shift      <= w_shift_nxt;
            r_mod_in     <= w_mod_in_nxt;
            r_mod_en     <= w_active_nxt;
            r_busy       <= w_active_nxt;
            r_done       <= w_done_nxt;
            r_underrun   <= w_underrun_nxt;
            r_byte_ready <= w_byte_ready_nxt;
        end
    end

    assign byte_ready = r_byte_ready;
    assign mod_en     = r_mod_en;
    assign mod_in     = r_mod_in;
    assign busy       = r_busy;
    assign done       = r_done;
    assign underrun   = r_underrun;

endmodule

`default_nettype wire
